// File: rtl/cic_integrator_chain_if.sv
// Sample stream bundle for the CIC integrator chain.
// Ports: i_ce/i_data into the chain, o_data/o_valid/o_dec_valid out of it.
interface cic_integrator_chain_if #(
  parameter int IW = 5,
  parameter int OW = 14
);
  logic          i_ce;
  logic [IW-1:0] i_data;
  logic [OW-1:0] o_data;
  logic          o_valid;
  logic          o_dec_valid;

  modport master (
    output i_ce,
    output i_data,
    input  o_data,
    input  o_valid,
    input  o_dec_valid
  );

  modport slave (
    input  i_ce,
    input  i_data,
    output o_data,
    output o_valid,
    output o_dec_valid
  );
endinterface

// File: rtl/cic_integrator_chain.sv
// N-stage cascaded CIC integrator with every-R-th sample flag.
// Ports: i_clk, i_reset_n (sync, active low), io_bus (slave stream).
module cic_integrator_chain #(
  parameter int IW = 5,
  parameter int N  = 3,
  parameter int R  = 8,
  parameter int OW = 14,
  parameter int CW = 3
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  cic_integrator_chain_if.slave  io_bus
);

  if (N < 1) begin : g_bad_n
    $fatal(1, "cic_integrator_chain: N must be >= 1");
  end
  if (R < 2) begin : g_bad_r
    $fatal(1, "cic_integrator_chain: R must be >= 2");
  end
  if (OW < IW + N * $clog2(R)) begin : g_bad_ow
    $fatal(1, "cic_integrator_chain: OW too narrow for growth");
  end
  if ((2 ** CW) < R) begin : g_bad_cw
    $fatal(1, "cic_integrator_chain: CW too narrow for R");
  end
  if ($bits(io_bus.i_data) != IW) begin : g_bad_ifi
    $fatal(1, "cic_integrator_chain: interface IW mismatch");
  end
  if ($bits(io_bus.o_data) != OW) begin : g_bad_ifo
    $fatal(1, "cic_integrator_chain: interface OW mismatch");
  end

  logic [OW-1:0] w_sext;
  logic [OW-1:0] w_in  [N];
  logic [OW-1:0] r_acc [N];
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_dec;
  logic          w_last;

  assign w_sext = {{(OW-IW){io_bus.i_data[IW-1]}}, io_bus.i_data};

  // Stage k adds the pre-edge value of stage k-1, giving one
  // sample of delay per stage after the first.
  always_comb begin
    w_in[0] = w_sext;
    for (int k = 1; k < N; k++) begin
      w_in[k] = r_acc[k-1];
    end
  end

  // Plain wrapping adds: the comb section cancels the overflow.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N; k++) begin
        r_acc[k] <= '0;
      end
    end else if (io_bus.i_ce) begin
      for (int k = 0; k < N; k++) begin
        r_acc[k] <= r_acc[k] + w_in[k];
      end
    end
  end

  assign w_last = (r_cnt == CW'(R - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_valid <= io_bus.i_ce;
      r_dec   <= io_bus.i_ce & w_last;
      if (io_bus.i_ce) begin
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

  assign io_bus.o_data      = r_acc[N-1];
  assign io_bus.o_valid     = r_valid;
  assign io_bus.o_dec_valid = r_dec;

endmodule
